// File: rtl/sweep_pkg.sv
// rtl/sweep_pkg.sv - shared state encoding and code constants for the control sweep checker
package sweep_pkg;

  typedef enum logic {
    IDLE,
    DRIVE
  } state_e;

  localparam int         NUM_CODES = 4;
  localparam logic [1:0] LAST_CODE = 2'b11;

endpackage

// File: rtl/dwell_counter.sv
// rtl/dwell_counter.sv - per-code dwell down-counter, reloaded on load, flags zero
module dwell_counter #(
  parameter int DWELL = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic zero
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Holds at zero rather than wrapping; the owner reloads it when advancing codes.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = RELOAD;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/ctrl_sweep_checker.sv
// rtl/ctrl_sweep_checker.sv - sweeps control codes 00..11, captures data_i, compares to expected; SWEEP_MISMATCH_EN adds mismatch port
module ctrl_sweep_checker
  import sweep_pkg::*;
#(
  parameter int DWELL = 10,
  parameter int CW    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NUM_CODES-1:0] expected,
  input  logic                 data_i,
`ifdef SWEEP_MISMATCH_EN
  output logic [NUM_CODES-1:0] mismatch,
`endif
  output logic [CW-1:0]        control_o,
  output logic                 busy,
  output logic                 done,
  output logic [NUM_CODES-1:0] result,
  output logic                 pass
);

  state_e               state_q, state_d;
  logic [CW-1:0]        ctrl_q, ctrl_d;
  logic [NUM_CODES-1:0] exp_q, exp_d;
  logic [NUM_CODES-1:0] result_q, result_d;
  logic [NUM_CODES-1:0] result_upd;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
`ifdef SWEEP_MISMATCH_EN
  logic [NUM_CODES-1:0] mism_q, mism_d;
`endif

  logic cnt_load;
  logic cnt_en;
  logic cnt_zero;

  dwell_counter #(
    .DWELL(DWELL)
  ) u_dwell (
    .clk (clk),
    .rst (rst),
    .load(cnt_load),
    .en  (cnt_en),
    .zero(cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    exp_d    = exp_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    pass_d   = pass_q;
`ifdef SWEEP_MISMATCH_EN
    mism_d   = mism_q;
`endif
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    // The verdict must include the bit being captured on the final edge.
    result_upd         = result_q;
    result_upd[ctrl_q] = data_i;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = DRIVE;
          ctrl_d   = '0;
          cnt_load = 1'b1;
          exp_d    = expected;
          result_d = '0;
          pass_d   = 1'b0;
          busy_d   = 1'b1;
`ifdef SWEEP_MISMATCH_EN
          mism_d   = '0;
`endif
        end
      end
      DRIVE: begin
        cnt_en = 1'b1;
        if (cnt_zero) begin
          result_d = result_upd;
          if (ctrl_q != LAST_CODE) begin
            ctrl_d   = ctrl_q + CW'(1);
            cnt_load = 1'b1;
          end else begin
            state_d = IDLE;
            ctrl_d  = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (result_upd == exp_q);
`ifdef SWEEP_MISMATCH_EN
            mism_d  = result_upd ^ exp_q;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ctrl_q   <= '0;
      exp_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
`ifdef SWEEP_MISMATCH_EN
      mism_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      exp_q    <= exp_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
`ifdef SWEEP_MISMATCH_EN
      mism_q   <= mism_d;
`endif
    end
  end

  assign control_o = ctrl_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign pass      = pass_q;
`ifdef SWEEP_MISMATCH_EN
  assign mismatch  = mism_q;
`endif

endmodule

// File: tb/tb_ctrl_sweep_checker.sv
// tb/tb_ctrl_sweep_checker.sv - scoreboard bench for ctrl_sweep_checker (DWELL=10 and DWELL=1), SWEEP_MISMATCH_EN aware
module tb_ctrl_sweep_checker;

  typedef struct {
    logic [3:0] res;
    logic       pas;
    logic [3:0] mis;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start0, start1;
  logic [3:0] expected0, expected1;
  logic       data0, data1;
  logic [1:0] ctrl0, ctrl1;
  logic       busy0, busy1, done0, done1, pass0, pass1;
  logic [3:0] result0, result1;
`ifdef SWEEP_MISMATCH_EN
  logic [3:0] mism0, mism1;
`endif

  int   cyc = 0;
  int   mode0 = 0;
  int   pulse_cyc = -1;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t m0, m1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign data0 = (mode0 == 1) ? (cyc == pulse_cyc) : (&ctrl0);
  assign data1 = &ctrl1;

  ctrl_sweep_checker #(.DWELL(10), .CW(2)) u0 (
    .clk(clk), .rst(rst), .start(start0), .expected(expected0), .data_i(data0),
`ifdef SWEEP_MISMATCH_EN
    .mismatch(mism0),
`endif
    .control_o(ctrl0), .busy(busy0), .done(done0), .result(result0), .pass(pass0)
  );

  ctrl_sweep_checker #(.DWELL(1), .CW(2)) u1 (
    .clk(clk), .rst(rst), .start(start1), .expected(expected1), .data_i(data1),
`ifdef SWEEP_MISMATCH_EN
    .mismatch(mism1),
`endif
    .control_o(ctrl1), .busy(busy1), .done(done1), .result(result1), .pass(pass1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic go0(input logic [3:0] e, output int n0);
    expected0 = e;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    n0 = cyc;
    chk("u0_busy_after_start", busy0, 1'b1);
  endtask

  function automatic exp_t mk(input logic [3:0] r, input logic p, input logic [3:0] m, input int c);
    exp_t e;
    e.res = r; e.pas = p; e.mis = m; e.cyc = c;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && done0) begin
      chk("u0_done_expected", (q0.size() != 0), 1'b1);
      if (q0.size() != 0) begin
        m0 = q0.pop_front();
        chk("u0_result", result0, m0.res);
        chk("u0_pass", pass0, m0.pas);
        chk("u0_done_cycle", cyc, m0.cyc);
`ifdef SWEEP_MISMATCH_EN
        chk("u0_mismatch", mism0, m0.mis);
`endif
      end
    end
    if (!rst && done1) begin
      chk("u1_done_expected", (q1.size() != 0), 1'b1);
      if (q1.size() != 0) begin
        m1 = q1.pop_front();
        chk("u1_result", result1, m1.res);
        chk("u1_pass", pass1, m1.pas);
        chk("u1_done_cycle", cyc, m1.cyc);
`ifdef SWEEP_MISMATCH_EN
        chk("u1_mismatch", mism1, m1.mis);
`endif
      end
    end
  end

  initial begin
    int n0;
    rst = 1'b1;
    start0 = 1'b1;
    start1 = 1'b1;
    expected0 = 4'b1000;
    expected1 = 4'b1000;

    // Reset held with start high: outputs stay at reset values
    repeat (3) @(negedge clk);
    chk("rst_control", ctrl0, 2'b00);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_done", done0, 1'b0);
    chk("rst_result", result0, 4'b0000);
    chk("rst_pass", pass0, 1'b0);
    chk("rst_u1_busy", busy1, 1'b0);
`ifdef SWEEP_MISMATCH_EN
    chk("rst_mismatch", mism0, 4'b0000);
`endif
    start0 = 1'b0;
    start1 = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", busy0, 1'b0);

    // Basic sweep, expected matches
    go0(4'b1000, n0);
    q0.push_back(mk(4'b1000, 1'b1, 4'b0000, n0 + 40));
    chk("ctrl_at_0", ctrl0, 2'b00);
    wait_to(n0 + 9);  chk("ctrl_at_9", ctrl0, 2'b00);
    wait_to(n0 + 10); chk("ctrl_at_10", ctrl0, 2'b01);
    wait_to(n0 + 25); chk("ctrl_at_25", ctrl0, 2'b10);
    wait_to(n0 + 39); chk("ctrl_at_39", ctrl0, 2'b11);
    wait_to(n0 + 40); chk("busy_at_done", busy0, 1'b0);
    wait_to(n0 + 42);

    // Expected differs
    go0(4'b0001, n0);
    q0.push_back(mk(4'b1000, 1'b0, 4'b1001, n0 + 40));
    wait_to(n0 + 42);

    // start held high: back-to-back sweeps, expected changed mid-sweep
    expected0 = 4'b1000;
    start0 = 1'b1;
    @(negedge clk);
    n0 = cyc;
    q0.push_back(mk(4'b1000, 1'b1, 4'b0000, n0 + 40));
    q0.push_back(mk(4'b1000, 1'b0, 4'b1001, n0 + 81));
    q0.push_back(mk(4'b1000, 1'b1, 4'b0000, n0 + 122));
    wait_to(n0 + 5);  expected0 = 4'b0001;
    wait_to(n0 + 41); chk("rearm_busy", busy0, 1'b1);
    wait_to(n0 + 46); expected0 = 4'b1000;
    wait_to(n0 + 90); start0 = 1'b0;
    wait_to(n0 + 125);

    // Reset mid-sweep aborts with no done
    go0(4'b1000, n0);
    wait_to(n0 + 15);
    rst = 1'b1;
    #1;
    chk("abort_busy", busy0, 1'b0);
    chk("abort_control", ctrl0, 2'b00);
    chk("abort_result", result0, 4'b0000);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_to(n0 + 60);

    // Single-cycle data pulse at the code 01 sample point
    pulse_cyc = -1;
    mode0 = 1;
    expected0 = 4'b0010;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    n0 = cyc;
    pulse_cyc = n0 + 19;
    q0.push_back(mk(4'b0010, 1'b1, 4'b0000, n0 + 40));
    wait_to(n0 + 42);
    mode0 = 0;

    // DWELL=1 instance
    expected1 = 4'b1000;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    n0 = cyc;
    q1.push_back(mk(4'b1000, 1'b1, 4'b0000, n0 + 4));
    chk("u1_ctrl_at_0", ctrl1, 2'b00);
    wait_to(n0 + 2); chk("u1_ctrl_at_2", ctrl1, 2'b10);
    wait_to(n0 + 8);

    chk("u0_queue_drained", q0.size(), 0);
    chk("u1_queue_drained", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
